// File: rtl/jtframe_prog_buf.sv
// Buffers ROM download bytes in a small FIFO and replays them onto the SDRAM
// programming port as byte-lane writes, holding dwnld_busy until all are committed.
module jtframe_prog_buf #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned HEADER = 0,
    parameter int unsigned SWAB   = 0,
    parameter int unsigned AW     = 22
) (
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    output logic [AW-1:0] prog_addr,
    output logic [7:0]    prog_data,
    output logic [1:0]    prog_mask,
    output logic          prog_we,
    input  logic          prog_rdy,
    output logic          dwnld_busy,
    output logic          overflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    entry_t        mem_q [DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    entry_t        head_c;
    logic          hdr_ok_c, push_req_c, push_c, pop_c, drop_c;
    logic          empty_c, full_c, lane_c;
    logic          dl_q, overflow_q;

    state_t        state_q, state_d;
    logic [AW-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]    prog_data_q, prog_data_d;
    logic [1:0]    prog_mask_q, prog_mask_d;
    logic          prog_we_q, prog_we_d;

    // Header bytes are skipped; a zero-length header accepts every address.
    generate
        if (HEADER == 0) begin : g_nohdr
            assign hdr_ok_c = 1'b1;
        end else begin : g_hdr
            assign hdr_ok_c = (ioctl_addr >= AW'(HEADER));
        end
    endgenerate

    assign empty_c    = (wr_ptr_q == rd_ptr_q);
    assign full_c     = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign head_c     = mem_q[rd_ptr_q[PW-1:0]];
    assign push_req_c = ioctl_wr & downloading & hdr_ok_c;
    assign pop_c      = (state_q == ST_IDLE) & ~empty_c;
    assign push_c     = push_req_c & (~full_c | pop_c);
    assign drop_c     = push_req_c & full_c & ~pop_c;
    assign lane_c     = head_c.addr[0] ^ 1'(SWAB);

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk_rom) begin
        if (push_c) begin
            mem_q[wr_ptr_q[PW-1:0]] <= '{addr: ioctl_addr - AW'(HEADER), data: ioctl_data};
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dl_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (push_c) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            if (drop_c) begin
                overflow_q <= 1'b1;
            end else if (downloading && !dl_q) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= 2'b11;
            prog_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_mask_q <= prog_mask_d;
            prog_we_q   <= prog_we_d;
        end
    end

    // Write handshake: hold the request until the SDRAM acknowledges it.
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        prog_we_d   = prog_we_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    state_d     = ST_WRITE;
                    prog_we_d   = 1'b1;
                    prog_addr_d = {1'b0, head_c.addr[AW-1:1]};
                    prog_data_d = head_c.data;
                    prog_mask_d = lane_c ? 2'b01 : 2'b10;
                end
            end
            ST_WRITE: begin
                if (prog_rdy) begin
                    state_d     = ST_IDLE;
                    prog_we_d   = 1'b0;
                    prog_mask_d = 2'b11;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prog_we    = prog_we_q;
    assign overflow   = overflow_q;
    assign dwnld_busy = downloading | ~empty_c | prog_we_q;

endmodule
